pipe_stage_buffer: RTL

Parametrised pipeline stage register that supersedes the fixed-field inter-stage buffers. Carries a control vector, a data vector and N register-address fields between two pipeline stages with a valid/ready handshake. An optional two-entry skid keeps `in_ready` fully registered. Supports bubble injection, which marks the entry dead and forces its addresses to the null register, and a synchronous flush for branch redirects. Instantiated between ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_entry_reg.sv | 59 +++++
 rtl/pipe_stage_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the parametrised inter-stage pipeline buffer.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Widest ctrl/addr vector the masking helper handles.
    localparam int MASK_W = 256;

    localparam logic [MASK_W-1:0] NULL_ADDR_DEFAULT = {MASK_W{1'b1}};

    // Returns the bubble form of a ctrl/addr vector when bubble is set, else the value itself.
    function automatic logic [MASK_W-1:0] bubble_mask(
        input logic              bubble,
        input logic [MASK_W-1:0] value,
        input logic [MASK_W-1:0] null_form
    );
        logic [MASK_W-1:0] result;
        if (bubble) begin
            result = null_form;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot of the stage buffer: ctrl, data, addr and bubble flag.
// Ctrl and addr are stored already masked when the loaded entry is a bubble.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int                  CTRL_W   = 16,
    parameter int                  DATA_W   = 48,
    parameter int                  ADDR_TW  = 8,
    parameter logic [ADDR_TW-1:0]  NULL_VEC = {ADDR_TW{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_bubble,
    input  logic [CTRL_W-1:0]  i_ctrl,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [ADDR_TW-1:0] i_addr,
    output logic [CTRL_W-1:0]  o_ctrl,
    output logic [DATA_W-1:0]  o_data,
    output logic [ADDR_TW-1:0] o_addr,
    output logic               o_bubble
);

    logic [CTRL_W-1:0]  r_ctrl;
    logic [DATA_W-1:0]  r_data;
    logic [ADDR_TW-1:0] r_addr;
    logic               r_bubble;
    logic [CTRL_W-1:0]  w_ctrl_d;
    logic [ADDR_TW-1:0] w_addr_d;

    assign w_ctrl_d = CTRL_W'(bubble_mask(i_bubble, MASK_W'(i_ctrl), {MASK_W{1'b0}}));
    assign w_addr_d = ADDR_TW'(bubble_mask(i_bubble, MASK_W'(i_addr), MASK_W'(NULL_VEC)));

    // Slot storage; data is kept unmasked so bubbles still carry their payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= {CTRL_W{1'b0}};
            r_data   <= {DATA_W{1'b0}};
            r_addr   <= NULL_VEC;
            r_bubble <= 1'b1;
        end else if (i_load) begin
            r_ctrl   <= w_ctrl_d;
            r_data   <= i_data;
            r_addr   <= w_addr_d;
            r_bubble <= i_bubble;
        end else begin
            r_ctrl   <= r_ctrl;
            r_data   <= r_data;
            r_addr   <= r_addr;
            r_bubble <= r_bubble;
        end
    end

    assign o_ctrl   = r_ctrl;
    assign o_data   = r_data;
    assign o_addr   = r_addr;
    assign o_bubble = r_bubble;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline stage register with optional two-entry skid,
// bubble injection and synchronous flush.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int                 CTRL_W    = 16,
    parameter int                 DATA_W    = 48,
    parameter int                 ADDR_W    = 4,
    parameter int                 NUM_ADDR  = 2,
    parameter logic [ADDR_W-1:0]  NULL_ADDR = NULL_ADDR_DEFAULT[ADDR_W-1:0],
    parameter int                 SKID      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [NUM_ADDR*ADDR_W-1:0]   in_addr,
    input  logic                         make_bubble,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    output logic [NUM_ADDR*ADDR_W-1:0]   out_addr,
    output logic                         out_bubble,
    output logic [1:0]                   occupancy
);

    localparam int                 ADDR_TW  = NUM_ADDR * ADDR_W;
    localparam logic [ADDR_TW-1:0] NULL_VEC = {NUM_ADDR{NULL_ADDR}};

    pipe_state_e        r_state;
    pipe_state_e        w_next_state;
    logic [1:0]         w_next_occ;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [1:0]         r_occupancy;

    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_main_load;
    logic               w_main_sel_skid;
    logic               w_skid_load;

    logic [CTRL_W-1:0]  w_main_ctrl;
    logic [DATA_W-1:0]  w_main_data;
    logic [ADDR_TW-1:0] w_main_addr;
    logic               w_main_bubble;
    logic [CTRL_W-1:0]  w_skid_ctrl;
    logic [DATA_W-1:0]  w_skid_data;
    logic [ADDR_TW-1:0] w_skid_addr;
    logic               w_skid_bubble;

    logic [CTRL_W-1:0]  w_main_ctrl_d;
    logic [DATA_W-1:0]  w_main_data_d;
    logic [ADDR_TW-1:0] w_main_addr_d;
    logic               w_main_bubble_d;

    // With a skid the ready is a pure flop; without one it must see out_ready to keep full rate.
    assign w_in_ready = (SKID != 0) ? r_in_ready : (!r_out_valid || out_ready);
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // State register plus the registered handshake/occupancy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != ST_FULL);
            r_out_valid <= (w_next_state != ST_EMPTY);
            r_occupancy <= w_next_occ;
        end
    end

    // Next-state logic; flush overrides every handshake event.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) w_next_state = ST_ONE;
                    else           w_next_state = ST_EMPTY;
                end
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer)      w_next_state = (SKID != 0) ? ST_FULL : ST_ONE;
                    else if (!w_in_xfer && w_out_xfer) w_next_state = ST_EMPTY;
                    else                               w_next_state = ST_ONE;
                end
                ST_FULL: begin
                    if (w_out_xfer) w_next_state = ST_ONE;
                    else            w_next_state = ST_FULL;
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
        case (w_next_state)
            ST_EMPTY: w_next_occ = 2'd0;
            ST_ONE:   w_next_occ = 2'd1;
            ST_FULL:  w_next_occ = 2'd2;
            default:  w_next_occ = 2'd0;
        endcase
    end

    // Slot load controls; a flush loads nothing so out_data keeps its last value.
    always_comb begin
        w_main_load     = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        if (flush) begin
            w_main_load = 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    w_main_load = w_in_xfer;
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) w_main_load = 1'b1;
                    else if (w_in_xfer)          w_skid_load = (SKID != 0);
                    else                         w_main_load = 1'b0;
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_main_load     = 1'b1;
                        w_main_sel_skid = 1'b1;
                    end else begin
                        w_main_load     = 1'b0;
                    end
                end
                default: w_main_load = 1'b0;
            endcase
        end
    end

    assign w_main_ctrl_d   = w_main_sel_skid ? w_skid_ctrl   : in_ctrl;
    assign w_main_data_d   = w_main_sel_skid ? w_skid_data   : in_data;
    assign w_main_addr_d   = w_main_sel_skid ? w_skid_addr   : in_addr;
    assign w_main_bubble_d = w_main_sel_skid ? w_skid_bubble : make_bubble;

    pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .ADDR_TW  (ADDR_TW),
        .NULL_VEC (NULL_VEC)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_main_load),
        .i_bubble (w_main_bubble_d),
        .i_ctrl   (w_main_ctrl_d),
        .i_data   (w_main_data_d),
        .i_addr   (w_main_addr_d),
        .o_ctrl   (w_main_ctrl),
        .o_data   (w_main_data),
        .o_addr   (w_main_addr),
        .o_bubble (w_main_bubble)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry_reg #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .ADDR_TW  (ADDR_TW),
                .NULL_VEC (NULL_VEC)
            ) u_skid (
                .clk      (clk),
                .rst      (rst),
                .i_load   (w_skid_load),
                .i_bubble (make_bubble),
                .i_ctrl   (in_ctrl),
                .i_data   (in_data),
                .i_addr   (in_addr),
                .o_ctrl   (w_skid_ctrl),
                .o_data   (w_skid_data),
                .o_addr   (w_skid_addr),
                .o_bubble (w_skid_bubble)
            );
        end else begin : g_no_skid
            assign w_skid_ctrl   = {CTRL_W{1'b0}};
            assign w_skid_data   = {DATA_W{1'b0}};
            assign w_skid_addr   = NULL_VEC;
            assign w_skid_bubble = 1'b1;
        end
    endgenerate

    // An empty stage presents a bubble so the hazard unit sees no live register.
    assign out_valid  = r_out_valid;
    assign out_ctrl   = CTRL_W'(bubble_mask(!r_out_valid, MASK_W'(w_main_ctrl), {MASK_W{1'b0}}));
    assign out_addr   = ADDR_TW'(bubble_mask(!r_out_valid, MASK_W'(w_main_addr), MASK_W'(NULL_VEC)));
    assign out_data   = w_main_data;
    assign out_bubble = !r_out_valid || w_main_bubble;
    assign occupancy  = r_occupancy;
    assign in_ready   = w_in_ready;

endmodule
